hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be: REG_W default 5, register-specifier width; LOAD_LAT default 1, load-use stall cycles, legal range 1..15; CNT_W default 16, stall counter width; ZERO_EXEMPT default 1, where 1 means register 0 never raises a hazard.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- idex_rt  in  REG_W  load destination in ID/EX.
- idex_memread  in  1  ID/EX holds a load.
- ifid_rs  in  REG_W  source 1 of the IF/ID instruction.
- ifid_rt  in  REG_W  source 2 of the IF/ID instruction.
- ifid_uses_rt  in  1  IF/ID instruction reads rt.
- branch_taken  in  1  taken-branch redirect this cycle.
- mem_busy  in  1  data memory not ready; the whole pipe must hold.
- stall_clr  in  1  synchronous clear of stall_count.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID update enable.
- hazard_mux  out  1  1 selects zeroed control into ID/EX (bubble).
- ifid_flush  out  1  zero IF/ID on the next edge.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- stall_count  out  CNT_W  count of cycles with pc_write=0.

Function
REQ-003 match SHALL be: idex_memread & ok & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)).
- ok is (idex_rt!=0) when ZERO_EXEMPT=1.
- ok is 1 when ZERO_EXEMPT=0.
REQ-004 The FSM SHALL have two states, RUN and LU_STALL, plus a remaining-stall counter rem of 4 bits.
REQ-005 pc_write, ifid_write, hazard_mux, ifid_flush and pipe_hold SHALL be combinational from state, rem and the current inputs, with zero-cycle latency.
REQ-006 Priority 1, mem_busy=1: SHALL drive pipe_hold=1, pc_write=0, ifid_write=0, hazard_mux=0, ifid_flush=0; state and rem SHALL be frozen; branch_taken and match SHALL be ignored.
REQ-007 Priority 2, branch_taken=1 with mem_busy=0: SHALL drive ifid_flush=1, pc_write=1, ifid_write=1, hazard_mux=0, pipe_hold=0; next state SHALL be RUN with rem=0, aborting any load-use stall in progress.
REQ-008 RUN with match=1 and no higher-priority event: SHALL drive pc_write=0, ifid_write=0, hazard_mux=1.
- If LOAD_LAT>1, next state SHALL be LU_STALL with rem=LOAD_LAT-1.
- If LOAD_LAT=1, state SHALL remain RUN.
REQ-009 LU_STALL with no higher-priority event: SHALL drive pc_write=0, ifid_write=0, hazard_mux=1, ignoring match.
- rem SHALL decrement by 1.
- When rem==1, next state SHALL be RUN.
REQ-010 RUN with no event: SHALL drive pc_write=1, ifid_write=1, hazard_mux=0, ifid_flush=0, pipe_hold=0.
REQ-011 Each load-use hazard SHALL produce exactly LOAD_LAT consecutive bubble cycles, excluding cycles frozen by mem_busy.
REQ-012 stall_count SHALL update on each rising edge as follows:
- stall_clr=1: next value 0, even if a stall is active.
- Otherwise, when pc_write=0: increment by 1.
- Saturate at 2^CNT_W-1; never wrap.
REQ-013 The outputs SHALL never assert ifid_flush and hazard_mux together, and SHALL never assert pipe_hold with pc_write=1.

Reset
REQ-014 rst_n=0 SHALL immediately force:
- state RUN, rem 0, stall_count 0;
- pc_write=1, ifid_write=1;
- hazard_mux=0, ifid_flush=0, pipe_hold=0.
These values SHALL hold regardless of the other inputs.
REQ-015 Reset asserted mid-stall SHALL abandon the stall; after reset release the block SHALL start in RUN with no residual bubbles.

Verification
REQ-016 LOAD_LAT=1, idex_memread=1, idex_rt=5, ifid_rs=5 for one cycle -> one cycle of pc_write=0 and hazard_mux=1; stall_count=1.
REQ-017 LOAD_LAT=3, same hazard pulsed for one cycle, then ID/EX shows a bubble -> 3 consecutive bubble cycles, then RUN; stall_count=3.
REQ-018 ZERO_EXEMPT=1, idex_rt=0=ifid_rs with a load -> no stall. ifid_uses_rt=0 with rt-only match -> no stall.
REQ-019 LOAD_LAT=3, mem_busy=1 for 2 cycles during the 2nd bubble cycle -> pipe_hold=1 for 2 cycles, then 2 more bubble cycles; stall_count=5.
REQ-020 LOAD_LAT=3, branch_taken in the 2nd bubble cycle -> ifid_flush=1 and pc_write=1 that cycle; next cycle RUN.
REQ-021 CNT_W=4 with 20 stall cycles -> stall_count stays at 15. Then stall_clr=1 -> 0 on the next edge. rst_n low mid-stall -> outputs at reset values with no clock edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Load-use / branch / memory-wait hazard control for a 5-stage pipe.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
   parameter int REG_W       = 5,
   parameter int LOAD_LAT    = 1,
   parameter int CNT_W       = 16,
   parameter int ZERO_EXEMPT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] idex_rt,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             branch_taken,
   input  logic             mem_busy,
   input  logic             stall_clr,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             hazard_mux,
   output logic             ifid_flush,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } state_t;

   localparam logic [3:0]       c_rem_init = 4'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] c_cnt_max  = '1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_rem;
   logic [3:0]       w_rem_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_ok;
   logic             w_match;

   generate
      if (ZERO_EXEMPT != 0) begin : g_zero_exempt
         assign w_ok = |idex_rt;
      end else begin : g_no_exempt
         assign w_ok = 1'b1;
      end
   endgenerate

   assign w_match = idex_memread & w_ok &
                    ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_rem   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   // Outputs are also forced by rst_n directly so reset takes effect without an edge.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      hazard_mux  = 1'b0;
      ifid_flush  = 1'b0;
      pipe_hold   = 1'b0;
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      if (!rst_n) begin
         w_state_nxt = RUN;
         w_rem_nxt   = 4'd0;
      end else if (mem_busy) begin
         pipe_hold  = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (branch_taken) begin
         ifid_flush  = 1'b1;
         w_state_nxt = RUN;
         w_rem_nxt   = 4'd0;
      end else if (r_state == LU_STALL) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         hazard_mux = 1'b1;
         w_rem_nxt  = r_rem - 4'd1;
         if (r_rem <= 4'd1) begin
            w_state_nxt = RUN;
            w_rem_nxt   = 4'd0;
         end
      end else if (w_match) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         hazard_mux = 1'b1;
         if (LOAD_LAT > 1) begin
            w_state_nxt = LU_STALL;
            w_rem_nxt   = c_rem_init;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (stall_clr) begin
         r_cnt <= '0;
      end else if (!pc_write && (r_cnt != c_cnt_max)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign stall_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed vector table plus multi-cycle sequences for hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] idex_rt, ifid_rs, ifid_rt;
   logic       idex_memread, ifid_uses_rt, branch_taken, mem_busy, stall_clr;

   logic        pc_a, iw_a, mux_a, fl_a, hold_a;
   logic        pc_b, iw_b, mux_b, fl_b, hold_b;
   logic [3:0]  cnt_a;
   logic [15:0] cnt_b;
   logic [4:0]  a_out, b_out;

   int checks = 0;
   int errors = 0;

   assign a_out = {pc_a, iw_a, mux_a, fl_a, hold_a};
   assign b_out = {pc_b, iw_b, mux_b, fl_b, hold_b};

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4), .ZERO_EXEMPT(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .idex_rt(idex_rt), .idex_memread(idex_memread),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .branch_taken(branch_taken), .mem_busy(mem_busy), .stall_clr(stall_clr),
      .pc_write(pc_a), .ifid_write(iw_a), .hazard_mux(mux_a), .ifid_flush(fl_a),
      .pipe_hold(hold_a), .stall_count(cnt_a)
   );

   hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16), .ZERO_EXEMPT(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .idex_rt(idex_rt), .idex_memread(idex_memread),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .branch_taken(branch_taken), .mem_busy(mem_busy), .stall_clr(stall_clr),
      .pc_write(pc_b), .ifid_write(iw_b), .hazard_mux(mux_b), .ifid_flush(fl_b),
      .pipe_hold(hold_b), .stall_count(cnt_b)
   );

   // Expected output fields are {pc_write, ifid_write, hazard_mux, ifid_flush, pipe_hold}.
   typedef struct {
      logic [4:0] rt_ex;
      logic       mr;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses;
      logic       br;
      logic       busy;
      logic [4:0] exp_a;
      logic [4:0] exp_b;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      idex_rt      = 5'd5;
      idex_memread = 1'b0;
      ifid_rs      = 5'd1;
      ifid_rt      = 5'd2;
      ifid_uses_rt = 1'b0;
      branch_taken = 1'b0;
      mem_busy     = 1'b0;
      stall_clr    = 1'b0;
   endtask

   task automatic set_hazard();
      idex_rt      = 5'd5;
      idex_memread = 1'b1;
      ifid_rs      = 5'd5;
      ifid_rt      = 5'd0;
      ifid_uses_rt = 1'b0;
   endtask

   task automatic clear_counts(input string name);
      @(negedge clk);
      set_idle();
      stall_clr = 1'b1;
      @(negedge clk);
      stall_clr = 1'b0;
      #1 chk(name, {28'd0, cnt_a}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{5'd5, 1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11000, 5'b11000};
      vecs[1] = '{5'd5, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00100, 5'b00100};
      vecs[2] = '{5'd5, 1'b1, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 5'b00100, 5'b00100};
      vecs[3] = '{5'd5, 1'b1, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 5'b11000, 5'b11000};
      vecs[4] = '{5'd0, 1'b1, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 5'b11000, 5'b00100};
      vecs[5] = '{5'd7, 1'b1, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11010, 5'b11010};
      vecs[6] = '{5'd7, 1'b1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 5'b00001, 5'b00001};
      vecs[7] = '{5'd7, 1'b0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 5'b00001, 5'b00001};
      vecs[8] = '{5'd5, 1'b1, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0, 5'b11000, 5'b11000};

      // Reset with a hazard and a busy memory presented: outputs must still be idle.
      rst_n = 1'b0;
      set_idle();
      set_hazard();
      mem_busy = 1'b1;
      #3;
      chk("rst_out_a", {27'd0, a_out}, {27'd0, 5'b11000});
      chk("rst_out_b", {27'd0, b_out}, {27'd0, 5'b11000});
      chk("rst_cnt_a", {28'd0, cnt_a}, 32'd0);
      @(negedge clk);
      set_idle();
      rst_n = 1'b1;

      // Combinational decode from RUN; inputs go idle again before each rising edge.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         idex_rt      = vecs[i].rt_ex;
         idex_memread = vecs[i].mr;
         ifid_rs      = vecs[i].rs;
         ifid_rt      = vecs[i].rt;
         ifid_uses_rt = vecs[i].uses;
         branch_taken = vecs[i].br;
         mem_busy     = vecs[i].busy;
         #1;
         chk($sformatf("vec%0d_a", i), {27'd0, a_out}, {27'd0, vecs[i].exp_a});
         chk($sformatf("vec%0d_b", i), {27'd0, b_out}, {27'd0, vecs[i].exp_b});
         #1 set_idle();
      end

      // One-cycle load-use pulse: A (latency 3) bubbles three times, B (latency 1) once.
      @(negedge clk);
      set_hazard();
      #1 chk("lu_c0_a", {27'd0, a_out}, {27'd0, 5'b00100});
      chk("lu_c0_b", {27'd0, b_out}, {27'd0, 5'b00100});
      @(negedge clk);
      set_idle();
      #1 chk("lu_c1_a", {27'd0, a_out}, {27'd0, 5'b00100});
      chk("lu_c1_b", {27'd0, b_out}, {27'd0, 5'b11000});
      chk("lu_cnt_b", {16'd0, cnt_b}, 32'd1);
      @(negedge clk);
      #1 chk("lu_c2_a", {27'd0, a_out}, {27'd0, 5'b00100});
      @(negedge clk);
      #1 chk("lu_c3_a", {27'd0, a_out}, {27'd0, 5'b11000});
      chk("lu_cnt_a", {28'd0, cnt_a}, 32'd3);

      // Memory wait inside the stall: two held cycles, then the two remaining bubbles.
      clear_counts("clr1");
      @(negedge clk);
      set_hazard();
      #1 chk("mb_c0", {27'd0, a_out}, {27'd0, 5'b00100});
      @(negedge clk);
      set_idle();
      mem_busy = 1'b1;
      #1 chk("mb_c1", {27'd0, a_out}, {27'd0, 5'b00001});
      @(negedge clk);
      #1 chk("mb_c2", {27'd0, a_out}, {27'd0, 5'b00001});
      @(negedge clk);
      mem_busy = 1'b0;
      #1 chk("mb_c3", {27'd0, a_out}, {27'd0, 5'b00100});
      @(negedge clk);
      #1 chk("mb_c4", {27'd0, a_out}, {27'd0, 5'b00100});
      @(negedge clk);
      #1 chk("mb_c5", {27'd0, a_out}, {27'd0, 5'b11000});
      chk("mb_cnt", {28'd0, cnt_a}, 32'd5);

      // Taken branch in the second bubble aborts the stall.
      clear_counts("clr2");
      @(negedge clk);
      set_hazard();
      #1 chk("br_c0", {27'd0, a_out}, {27'd0, 5'b00100});
      @(negedge clk);
      set_idle();
      branch_taken = 1'b1;
      #1 chk("br_c1", {27'd0, a_out}, {27'd0, 5'b11010});
      @(negedge clk);
      branch_taken = 1'b0;
      #1 chk("br_c2", {27'd0, a_out}, {27'd0, 5'b11000});
      chk("br_cnt", {28'd0, cnt_a}, 32'd1);

      // Saturation of the 4-bit counter, clear during an active stall, then async reset.
      clear_counts("clr3");
      @(negedge clk);
      set_hazard();
      repeat (20) @(posedge clk);
      @(negedge clk);
      #1 chk("sat_cnt_a", {28'd0, cnt_a}, 32'd15);
      chk("sat_cnt_b", {16'd0, cnt_b}, 32'd20);
      chk("sat_out_a", {27'd0, a_out}, {27'd0, 5'b00100});
      stall_clr = 1'b1;
      @(negedge clk);
      stall_clr = 1'b0;
      #1 chk("clr_mid_stall", {28'd0, cnt_a}, 32'd0);
      #1 rst_n = 1'b0;
      #1 chk("arst_out_a", {27'd0, a_out}, {27'd0, 5'b11000});
      chk("arst_out_b", {27'd0, b_out}, {27'd0, 5'b11000});
      chk("arst_cnt_b", {16'd0, cnt_b}, 32'd0);
      @(negedge clk);
      set_idle();
      rst_n = 1'b1;
      #1 chk("post_rst_c0", {27'd0, a_out}, {27'd0, 5'b11000});
      @(negedge clk);
      #1 chk("post_rst_c1", {27'd0, a_out}, {27'd0, 5'b11000});
      chk("post_rst_cnt", {28'd0, cnt_a}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
